block_align: RTL and testbench

- Sits directly downstream of block_sync and consumes its block_offset together with the same gearbox buffer.
- Slices one 66b block per buffer_dv from gbox_buffer at the chosen offset and splits it into a 2b header and a 64b payload.
- Runs a header-lock state machine. Emits aligned blocks to the frame decoder only while locked.

---
 rtl/block_align.sv | 194 +++++++++++++++++++
 tb/tb_block_align.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_align.sv
// block_align: slices one 66b block per buffer_dv out of the gearbox buffer at
// the offset found by block_sync, splits it into header and payload, and runs
// a header-lock state machine. Aligned blocks are flagged valid only while
// locked.
//
// Optional build macro BLOCK_ALIGN_DESCRAMBLE_EN: when defined, data_o carries
// the payload after a self-synchronising x^58+x^39+1 descrambler.
//
// Offset handling: while UNLOCKED the slice uses the (clamped) block_offset of
// the same cycle, so the offset register and the evaluated block always agree.
// A TRACKING cycle in which block_offset moves drops that cycle's block
// entirely (no header/data update, no hdr_err_o). The descrambler still
// advances on it.

module block_align #(
    parameter int LOCK_CNT   = 32,
    parameter int WIN_LEN    = 64,
    parameter int UNLOCK_BAD = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [193:0] gbox_buffer,
    input  logic [5:0]   gbox_cnt,
    input  logic         buffer_dv,
    input  logic [6:0]   block_offset,
    output logic [1:0]   header_o,
    output logic [63:0]  data_o,
    output logic         data_valid_o,
    output logic         locked_o,
    output logic [6:0]   offset_o,
    output logic         hdr_err_o
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        TRACKING = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    localparam logic [5:0] LOCK_TGT = 6'(LOCK_CNT);
    localparam logic [7:0] WIN_TGT  = 8'(WIN_LEN);
    localparam logic [7:0] BAD_TGT  = 8'(UNLOCK_BAD);

    state_t      state;
    logic [5:0]  good_cnt;
    logic [7:0]  win_cnt;
    logic [7:0]  bad_cnt;
    logic [6:0]  offset_q;

    logic [6:0]  req_offset;
    logic [6:0]  slice_offset;
    logic [7:0]  low_idx;
    logic [65:0] blk;
    logic        hdr_ok;
    logic        offset_jump;
    logic [5:0]  good_inc;
    logic [7:0]  win_inc;
    logic [7:0]  bad_inc;
    logic [63:0] payload_out;

    // Block selection and per-block header classification.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        req_offset   = (block_offset > 7'd65) ? 7'd65 : block_offset;
        slice_offset = (state == UNLOCKED) ? req_offset : offset_q;
        // Low bit of the block: 193 - cnt - offset - 65; never negative for legal inputs.
        low_idx      = 8'd128 - {2'b00, gbox_cnt} - {1'b0, slice_offset};
        blk          = gbox_buffer[low_idx +: 66];
        hdr_ok       = blk[65] ^ blk[64];
        offset_jump  = (state == TRACKING) && (req_offset != offset_q);
        good_inc     = good_cnt + 6'd1;
        win_inc      = win_cnt + 8'd1;
        bad_inc      = bad_cnt + {7'd0, ~hdr_ok};
    end

`ifdef BLOCK_ALIGN_DESCRAMBLE_EN
    logic [57:0] scr_q;
    logic [57:0] scr_walk;

    // Descramble the raw payload LSB first; the raw bit feeds the state.
    always_comb begin
        // NOTE: blocking assignments here are deliberate: scr_walk is a running
        // value updated bit by bit within one evaluation.
        scr_walk = scr_q;
        payload_out = '0;
        for (int i = 0; i < 64; i++) begin
            payload_out[i] = blk[i] ^ scr_walk[38] ^ scr_walk[57];
            scr_walk       = {scr_walk[56:0], blk[i]};
        end
    end

    // Descrambler state advances on every block regardless of lock state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scr_q <= '0;
        end else if (buffer_dv) begin
            scr_q <= scr_walk;
        end
    end
`else
    // Without the descrambler the payload passes through untouched.
    always_comb begin
        payload_out = blk[63:0];
    end
`endif

    assign offset_o = offset_q;

    // Header-lock state machine with registered outputs.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (rst_i) begin
            state        <= UNLOCKED;
            good_cnt     <= '0;
            win_cnt      <= '0;
            bad_cnt      <= '0;
            offset_q     <= '0;
            header_o     <= '0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            locked_o     <= 1'b0;
            hdr_err_o    <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;
            hdr_err_o    <= 1'b0;
            if (state == UNLOCKED) begin
                offset_q <= req_offset;
            end
            if (offset_jump) begin
                offset_q <= req_offset;
                good_cnt <= '0;
                state    <= UNLOCKED;
            end else if (buffer_dv) begin
                header_o  <= blk[65:64];
                data_o    <= payload_out;
                hdr_err_o <= ~hdr_ok;
                case (state)
                    UNLOCKED: begin
                        if (hdr_ok) begin
                            good_cnt <= 6'd1;
                            if (LOCK_TGT == 6'd1) begin
                                state    <= LOCKED;
                                locked_o <= 1'b1;
                                win_cnt  <= '0;
                                bad_cnt  <= '0;
                            end else begin
                                state <= TRACKING;
                            end
                        end
                    end
                    TRACKING: begin
                        if (!hdr_ok) begin
                            good_cnt <= '0;
                            state    <= UNLOCKED;
                        end else begin
                            if (good_cnt < LOCK_TGT) begin
                                good_cnt <= good_inc;
                            end
                            if (good_inc == LOCK_TGT) begin
                                state    <= LOCKED;
                                locked_o <= 1'b1;
                                win_cnt  <= '0;
                                bad_cnt  <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        if (bad_inc == BAD_TGT) begin
                            state    <= UNLOCKED;
                            locked_o <= 1'b0;
                            good_cnt <= '0;
                            win_cnt  <= '0;
                            bad_cnt  <= '0;
                        end else begin
                            data_valid_o <= 1'b1;
                            if (win_inc == WIN_TGT) begin
                                win_cnt <= '0;
                                bad_cnt <= '0;
                            end else begin
                                win_cnt <= win_inc;
                                bad_cnt <= bad_inc;
                            end
                        end
                    end
                    default: begin
                        state <= UNLOCKED;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_block_align.sv
// Self-checking bench for block_align. A behavioural model predicts every
// output one cycle after each driven cycle; directed phases add hand-computed
// expectations at the lock/unlock boundaries and the extreme slice positions.

module tb_block_align;

    localparam int LOCK_CNT   = 32;
    localparam int WIN_LEN    = 64;
    localparam int UNLOCK_BAD = 16;

    localparam int S_UNL = 0;
    localparam int S_TRK = 1;
    localparam int S_LCK = 2;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [193:0] gbox_buffer;
    logic [5:0]   gbox_cnt;
    logic         buffer_dv;
    logic [6:0]   block_offset;
    logic [1:0]   header_o;
    logic [63:0]  data_o;
    logic         data_valid_o;
    logic         locked_o;
    logic [6:0]   offset_o;
    logic         hdr_err_o;

    block_align #(
        .LOCK_CNT  (LOCK_CNT),
        .WIN_LEN   (WIN_LEN),
        .UNLOCK_BAD(UNLOCK_BAD)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .gbox_buffer (gbox_buffer),
        .gbox_cnt    (gbox_cnt),
        .buffer_dv   (buffer_dv),
        .block_offset(block_offset),
        .header_o    (header_o),
        .data_o      (data_o),
        .data_valid_o(data_valid_o),
        .locked_o    (locked_o),
        .offset_o    (offset_o),
        .hdr_err_o   (hdr_err_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    int err_pulses = 0;

    // Model state
    int          m_state = S_UNL;
    int          m_good = 0;
    int          m_win = 0;
    int          m_bad = 0;
    logic [6:0]  m_off = '0;
    logic [57:0] m_scr = '0;

    // Expected outputs after the next active edge
    logic [1:0]  exp_header = '0;
    logic [63:0] exp_data = '0;
    logic        exp_valid = 1'b0;
    logic        exp_locked = 1'b0;
    logic [6:0]  exp_off = '0;
    logic        exp_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model shortly after each active edge.
    always @(posedge clk_i) begin
        #2;
        if (chk_en) begin
            check("header_o", 64'(header_o), 64'(exp_header));
            check("data_o", data_o, exp_data);
            check("data_valid_o", 64'(data_valid_o), 64'(exp_valid));
            check("locked_o", 64'(locked_o), 64'(exp_locked));
            check("offset_o", 64'(offset_o), 64'(exp_off));
            check("hdr_err_o", 64'(hdr_err_o), 64'(exp_err));
            if (hdr_err_o) err_pulses++;
        end
    end

    // Drive one cycle (called at a falling edge), advance the model, then wait
    // for the next falling edge so the outputs of this cycle are visible.
    // The block is placed where the specification says the DUT must look; the
    // rest of the buffer is random so a wrong slice position is exposed.
    // Expected data_o is always the plaintext.
    task automatic step(input bit rst, input bit dv, input logic [6:0] boff,
                        input logic [5:0] gcnt, input logic [1:0] hdr,
                        input logic [63:0] plain);
        logic [6:0]   eoff;
        logic [6:0]   soff;
        int           low;
        logic [63:0]  pay;
        logic [193:0] buf_v;
        bit           hdr_valid;
        bit           dropped;
`ifdef BLOCK_ALIGN_DESCRAMBLE_EN
        logic [57:0]  s;
`endif
        eoff = (boff > 7'd65) ? 7'd65 : boff;
        soff = (m_state == S_UNL) ? eoff : m_off;
        pay  = plain;
`ifdef BLOCK_ALIGN_DESCRAMBLE_EN
        if (rst) begin
            m_scr = '0;
        end else if (dv) begin
            s = m_scr;
            for (int i = 0; i < 64; i++) begin
                pay[i] = plain[i] ^ s[38] ^ s[57];
                s = {s[56:0], pay[i]};
            end
            m_scr = s;
        end
`endif
        buf_v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        low = 128 - int'(gcnt) - int'(soff);
        buf_v[low +: 66] = {hdr, pay};

        rst_i        = rst;
        buffer_dv    = dv;
        block_offset = boff;
        gbox_cnt     = gcnt;
        gbox_buffer  = buf_v;

        if (rst) begin
            m_state = S_UNL; m_good = 0; m_win = 0; m_bad = 0; m_off = '0;
            exp_header = '0; exp_data = '0; exp_valid = 0; exp_locked = 0;
            exp_off = '0; exp_err = 0;
        end else begin
            exp_valid = 0;
            exp_err   = 0;
            dropped = (m_state == S_TRK) && (eoff != m_off);
            if (m_state == S_UNL || dropped) m_off = eoff;
            if (dropped) begin
                m_state = S_UNL;
                m_good  = 0;
            end else if (dv) begin
                hdr_valid  = (hdr == 2'b01) || (hdr == 2'b10);
                exp_header = hdr;
                exp_data   = plain;
                exp_err    = !hdr_valid;
                case (m_state)
                    S_UNL: if (hdr_valid) begin
                        m_good = 1;
                        if (m_good == LOCK_CNT) begin
                            m_state = S_LCK; m_win = 0; m_bad = 0;
                        end else m_state = S_TRK;
                    end
                    S_TRK: if (!hdr_valid) begin
                        m_good = 0; m_state = S_UNL;
                    end else begin
                        m_good++;
                        if (m_good == LOCK_CNT) begin
                            m_state = S_LCK; m_win = 0; m_bad = 0;
                        end
                    end
                    default: begin
                        m_win++;
                        if (!hdr_valid) m_bad++;
                        if (m_bad == UNLOCK_BAD) begin
                            m_state = S_UNL; m_good = 0; m_win = 0; m_bad = 0;
                        end else begin
                            exp_valid = 1;
                            if (m_win == WIN_LEN) begin
                                m_win = 0; m_bad = 0;
                            end
                        end
                    end
                endcase
            end
            exp_locked = (m_state == S_LCK);
            exp_off    = m_off;
        end
        @(negedge clk_i);
    endtask

    function automatic logic [5:0] rnd_cnt();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic good_blk(input logic [6:0] boff);
        step(0, 1, boff, rnd_cnt(), good_hdr(), {$urandom, $urandom});
    endtask

    task automatic bad_blk(input logic [6:0] boff);
        step(0, 1, boff, rnd_cnt(), ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11,
             {$urandom, $urandom});
    endtask

    task automatic lock_at(input logic [6:0] boff);
        step(1, 0, boff, 6'd0, 2'b01, 64'd0);
        for (int i = 0; i < LOCK_CNT; i++) good_blk(boff);
    endtask

    initial begin
        int base;
        logic [6:0] cur_boff;
        int bad_pct;
        bit dv;
        logic [1:0] hdr;

        rst_i = 1; buffer_dv = 0; block_offset = '0; gbox_cnt = '0; gbox_buffer = '0;
        @(negedge clk_i);
        chk_en = 1'b1;

        // Reset state, with buffer_dv high as well: reset wins.
        step(1, 1, 7'd5, 6'd10, 2'b01, 64'h1111_2222_3333_4444);
        check("rst_locked", 64'(locked_o), 64'd0);
        check("rst_header", 64'(header_o), 64'd0);
        check("rst_offset", 64'(offset_o), 64'd0);

        // Lock at offset 5 after exactly 32 good headers.
        for (int b = 1; b <= 40; b++) begin
            step(0, 1, 7'd5, rnd_cnt(), 2'b01, 64'hA5A5_0000_FFFF_1234);
            if (b == 31) check("t1_not_locked_31", 64'(locked_o), 64'd0);
            if (b == 32) begin
                check("t1_locked_32", 64'(locked_o), 64'd1);
                check("t1_novalid_32", 64'(data_valid_o), 64'd0);
            end
            if (b == 33) begin
                check("t1_valid_33", 64'(data_valid_o), 64'd1);
                check("t1_data_33", data_o, 64'hA5A5_0000_FFFF_1234);
                check("t1_offset_33", 64'(offset_o), 64'd5);
            end
        end

        // Offset change while tracking restarts the lock count.
        step(1, 0, 7'd5, 6'd0, 2'b01, 64'd0);
        for (int i = 0; i < 20; i++) good_blk(7'd5);
        step(0, 0, 7'd17, 6'd0, 2'b01, 64'd0);
        check("t2_offset_17", 64'(offset_o), 64'd17);
        for (int i = 0; i < LOCK_CNT - 1; i++) good_blk(7'd17);
        check("t2_not_locked_31", 64'(locked_o), 64'd0);
        good_blk(7'd17);
        check("t2_locked_32", 64'(locked_o), 64'd1);

        // 15 bad headers in a window keep lock; 16 in one window lose it.
        lock_at(7'd30);
        base = err_pulses;
        for (int i = 0; i < WIN_LEN; i++) begin
            if (i % 4 == 0 && i < 60) bad_blk(7'd30); else good_blk(7'd30);
        end
        check("t3_err_pulses_15", 64'(err_pulses - base), 64'd15);
        check("t3_still_locked", 64'(locked_o), 64'd1);
        for (int i = 1; i <= UNLOCK_BAD; i++) begin
            bad_blk(7'd30);
            if (i == UNLOCK_BAD - 1) check("t3_locked_15th", 64'(locked_o), 64'd1);
        end
        check("t3_unlock_16th", 64'(locked_o), 64'd0);
        check("t3_err_16th", 64'(hdr_err_o), 64'd1);
        check("t3_novalid_16th", 64'(data_valid_o), 64'd0);

        // Tumbling window: 15 bad in each of two consecutive windows.
        lock_at(7'd9);
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < WIN_LEN; i++)
                if (i < 15) bad_blk(7'd9); else good_blk(7'd9);
        check("t4_locked", 64'(locked_o), 64'd1);

        // Reset mid-lock drops lock on the next edge.
        step(1, 1, 7'd9, 6'd0, 2'b01, 64'd0);
        check("rst_mid_lock", 64'(locked_o), 64'd0);

        // Deepest and shallowest slices, plus clamping of offsets above 65.
        step(0, 1, 7'd65, 6'd63, 2'b10, 64'hDEAD_BEEF_0123_4567);
        check("t5_deep_hdr", 64'(header_o), 64'd2);
        check("t5_deep_data", data_o, 64'hDEAD_BEEF_0123_4567);
        step(1, 0, 7'd0, 6'd0, 2'b01, 64'd0);
        step(0, 1, 7'd0, 6'd0, 2'b01, 64'h0F0F_1234_5678_9ABC);
        check("t5_top_hdr", 64'(header_o), 64'd1);
        check("t5_top_data", data_o, 64'h0F0F_1234_5678_9ABC);
        step(1, 0, 7'd100, 6'd0, 2'b01, 64'd0);
        step(0, 1, 7'd100, 6'd63, 2'b10, 64'h7777_0000_1111_2222);
        check("t5_clamp_data", data_o, 64'h7777_0000_1111_2222);
        check("t5_clamp_offset", 64'(offset_o), 64'd65);

        // Randomised traffic with alternating clean and noisy stretches.
        cur_boff = 7'd12;
        for (int seg = 0; seg < 12; seg++) begin
            bad_pct = (seg % 2 == 0) ? 1 : 35;
            for (int c = 0; c < 300; c++) begin
                dv = ($urandom_range(0, 9) < 7);
                if (!dv && $urandom_range(0, 59) == 0) cur_boff = 7'($urandom_range(0, 70));
                if ($urandom_range(0, 99) < bad_pct)
                    hdr = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
                else
                    hdr = good_hdr();
                step($urandom_range(0, 999) == 0, dv, cur_boff, rnd_cnt(), hdr,
                     {$urandom, $urandom});
            end
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
